// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush controller for the 4-stage core (IF, ID, EX, WB).
// It tracks the instruction and data memory handshakes, RAW hazards between
// ID sources and EX/WB destinations, the multi-cycle MDU, and taken branches
// that resolve in WB. From these it drives the per-register stall and flush
// controls, the PC enable and the instruction request.
//
// Ports
//   clk, rst_n                 core clock, synchronous active-low reset
//   fetch_en_i                 starts fetching; latched into a run flag until reset
//   instr_req_o                instruction memory request
//   instr_gnt_i/instr_rvalid_i instruction grant / rdata valid
//   data_req_i                 WB stage holds a load/store
//   data_gnt_i/data_rvalid_i   data grant / response valid
//   data_req_en_o              WB may drive its data request (0 while awaiting rvalid)
//   id_rs1/rs2_addr_i, _used_i ID source registers and their liveness
//   ex_rd_addr_i, ex_write_en_i  EX destination
//   wb_rd_addr_i, wb_write_en_i  WB destination
//   mdu_start_i                EX holds an MDU op (first cycle)
//   branch_taken_i             WB branch/jump taken
//   pc_en_o                    PC loads its next value
//   stall_*_o / flush_*_o      hold / bubble control for IF_to_ID, ID_to_EX, EX_to_WB
module pipeline_sequencer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int MDU_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  output logic                  instr_req_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic                  data_req_en_o,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                  ex_write_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic                  wb_write_en_i,
  input  logic                  mdu_start_i,
  input  logic                  branch_taken_i,
  output logic                  pc_en_o,
  output logic                  stall_if_id_o,
  output logic                  stall_id_ex_o,
  output logic                  stall_ex_wb_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic                  flush_ex_wb_o
);

  typedef enum logic [1:0] {F_OFF, F_REQ, F_WAIT} fetch_state_t;
  typedef enum logic [1:0] {D_IDLE, D_GNT, D_WAIT} data_state_t;

  // Latencies of 0 and 1 both mean a single-cycle MDU that never stalls.
  localparam bit MDU_ON   = (MDU_LATENCY > 1);
  localparam int CNT_W    = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  localparam int MDU_LAST = MDU_ON ? MDU_LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LAST);

  logic         run_reg, run_next;
  fetch_state_t fetch_state_reg, fetch_state_next;
  data_state_t  data_state_reg, data_state_next;
  logic [CNT_W-1:0] mdu_cnt_reg, mdu_cnt_next;
  logic         discard_reg, discard_next;
  logic         instr_req_reg, data_req_en_reg;

  logic data_stall, fetch_valid, mdu_busy, hazard, branch_win;

  // ---------------- RAW hazard detection, one slice per ID source ----------
  logic [ADDR_WIDTH-1:0] src_addr [2];
  logic [1:0]            src_used;
  logic [1:0]            src_hazard;

  assign src_addr[0] = id_rs1_addr_i;
  assign src_addr[1] = id_rs2_addr_i;
  assign src_used    = {id_rs2_used_i, id_rs1_used_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // x0 is hardwired zero, so it can never carry a dependency.
      assign src_hazard[gi] = src_used[gi] && (src_addr[gi] != '0) &&
                              ((ex_write_en_i && (src_addr[gi] == ex_rd_addr_i)) ||
                               (wb_write_en_i && (src_addr[gi] == wb_rd_addr_i)));
    end
  endgenerate

  assign hazard = |src_hazard;

  // ---------------- status terms ----------------
  assign data_stall  = data_req_i && !((data_state_reg == D_WAIT) && data_rvalid_i);
  assign fetch_valid = (fetch_state_reg == F_WAIT) && instr_rvalid_i && !discard_reg;
  assign mdu_busy    = (mdu_cnt_reg != '0) || (MDU_ON && mdu_start_i);

  // ---------------- priority stall/flush decode ----------------
  // Each branch sets at most one of stall/flush per register, so flush
  // always wins by construction.
  always_comb begin
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    stall_ex_wb_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    flush_ex_wb_o = 1'b0;
    pc_en_o       = 1'b0;
    branch_win    = 1'b0;
    if (!run_reg || data_stall) begin
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
      stall_ex_wb_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      flush_ex_wb_o = 1'b1;
      pc_en_o       = 1'b1;
      branch_win    = 1'b1;
    end else if (mdu_busy) begin
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
      flush_ex_wb_o = 1'b1;
    end else if (hazard) begin
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (fetch_valid) begin
      pc_en_o = 1'b1;
    end else begin
      flush_if_id_o = 1'b1;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    run_next = run_reg || fetch_en_i;

    fetch_state_next = fetch_state_reg;
    case (fetch_state_reg)
      F_OFF:   if (run_next)       fetch_state_next = F_REQ;
      F_REQ:   if (instr_gnt_i)    fetch_state_next = F_WAIT;
      F_WAIT:  if (instr_rvalid_i) fetch_state_next = F_REQ;
      default:                     fetch_state_next = F_OFF;
    endcase

    data_state_next = data_state_reg;
    case (data_state_reg)
      D_IDLE:  if (data_req_i) data_state_next = data_gnt_i ? D_WAIT : D_GNT;
      D_GNT:   if (data_gnt_i)    data_state_next = D_WAIT;
      D_WAIT:  if (data_rvalid_i) data_state_next = D_IDLE;
      default:                    data_state_next = D_IDLE;
    endcase

    mdu_cnt_next = mdu_cnt_reg;
    if (mdu_cnt_reg != '0)
      mdu_cnt_next = mdu_cnt_reg - CNT_W'(1);
    else if (MDU_ON && mdu_start_i)
      mdu_cnt_next = MDU_LOAD;

    // A word granted before the branch (already waiting, or granted this very
    // cycle against the old PC) belongs to the wrong path and must be dropped.
    discard_next = discard_reg;
    if ((fetch_state_reg == F_WAIT) && instr_rvalid_i)
      discard_next = 1'b0;
    else if (branch_win &&
             (((fetch_state_reg == F_WAIT) && !instr_rvalid_i) ||
              ((fetch_state_reg == F_REQ) && instr_gnt_i)))
      discard_next = 1'b1;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_reg         <= 1'b0;
      fetch_state_reg <= F_OFF;
      data_state_reg  <= D_IDLE;
      mdu_cnt_reg     <= '0;
      discard_reg     <= 1'b0;
      instr_req_reg   <= 1'b0;
      data_req_en_reg <= 1'b1;
    end else begin
      run_reg         <= run_next;
      fetch_state_reg <= fetch_state_next;
      data_state_reg  <= data_state_next;
      mdu_cnt_reg     <= mdu_cnt_next;
      discard_reg     <= discard_next;
      instr_req_reg   <= (fetch_state_next == F_REQ);
      data_req_en_reg <= (data_state_next != D_WAIT);
    end
  end

  assign instr_req_o   = instr_req_reg;
  assign data_req_en_o = data_req_en_reg;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed and randomized check of pipeline_sequencer against a behavioural
// model of the stall/flush rules.
module tb_pipeline_sequencer;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fetch_en, instr_gnt, instr_rvalid;
  logic data_req, data_gnt, data_rvalid;
  logic [AW-1:0] rs1, rs2, ex_rd, wb_rd;
  logic rs1_used, rs2_used, ex_we, wb_we, mdu_start, branch;
  logic instr_req, data_req_en, pc_en;
  logic s_if_id, s_id_ex, s_ex_wb, f_if_id, f_id_ex, f_ex_wb;

  pipeline_sequencer #(.ADDR_WIDTH(AW), .MDU_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en),
    .instr_req_o(instr_req), .instr_gnt_i(instr_gnt), .instr_rvalid_i(instr_rvalid),
    .data_req_i(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_req_en_o(data_req_en),
    .id_rs1_addr_i(rs1), .id_rs1_used_i(rs1_used),
    .id_rs2_addr_i(rs2), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(ex_rd), .ex_write_en_i(ex_we),
    .wb_rd_addr_i(wb_rd), .wb_write_en_i(wb_we),
    .mdu_start_i(mdu_start), .branch_taken_i(branch), .pc_en_o(pc_en),
    .stall_if_id_o(s_if_id), .stall_id_ex_o(s_id_ex), .stall_ex_wb_o(s_ex_wb),
    .flush_if_id_o(f_if_id), .flush_id_ex_o(f_id_ex), .flush_ex_wb_o(f_ex_wb)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: what the memory interfaces and MDU are doing right now.
  bit m_run, m_fetch_asking, m_fetch_in_flight, m_discard;
  bit m_data_await_gnt, m_data_in_flight;
  int m_mdu_left;

  task automatic model_reset();
    m_run = 0; m_fetch_asking = 0; m_fetch_in_flight = 0; m_discard = 0;
    m_data_await_gnt = 0; m_data_in_flight = 0; m_mdu_left = 0;
  endtask

  function automatic bit src_hits(input logic [AW-1:0] a, input logic used);
    return used && (a != 0) && ((ex_we && a == ex_rd) || (wb_we && a == wb_rd));
  endfunction

  function automatic bit m_data_stall();
    return data_req && !(m_data_in_flight && data_rvalid);
  endfunction

  function automatic bit m_branch_wins();
    return m_run && !m_data_stall() && branch;
  endfunction

  // Expected {instr_req, pc_en, data_req_en, stall x3, flush x3}.
  function automatic logic [8:0] model_expect();
    bit busy, haz, fv;
    logic [2:0] st, fl;
    bit pce;
    st = 3'b000; fl = 3'b000; pce = 0;
    busy = (m_mdu_left > 0) || (mdu_start && LAT > 1);
    haz  = src_hits(rs1, rs1_used) || src_hits(rs2, rs2_used);
    fv   = m_fetch_in_flight && instr_rvalid && !m_discard;
    if (!m_run || m_data_stall()) st = 3'b111;
    else if (branch)              begin fl = 3'b111; pce = 1; end
    else if (busy)                begin st = 3'b110; fl = 3'b001; end
    else if (haz)                 begin st = 3'b100; fl = 3'b010; end
    else if (fv)                  pce = 1;
    else                          fl = 3'b100;
    return {m_fetch_asking, pce, !m_data_in_flight, st, fl};
  endfunction

  task automatic model_update();
    bit bw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    bw = m_branch_wins();
    if (bw && ((m_fetch_in_flight && !instr_rvalid) || (m_fetch_asking && instr_gnt)))
      m_discard = 1;
    if (m_fetch_in_flight && instr_rvalid) begin
      m_fetch_in_flight = 0; m_fetch_asking = 1; m_discard = 0;
    end else if (m_fetch_asking && instr_gnt) begin
      m_fetch_asking = 0; m_fetch_in_flight = 1;
    end else if (!m_fetch_asking && !m_fetch_in_flight && (m_run || fetch_en)) begin
      m_fetch_asking = 1;
    end
    m_run = m_run || fetch_en;
    if (m_data_in_flight) begin
      if (data_rvalid) m_data_in_flight = 0;
    end else if (m_data_await_gnt) begin
      if (data_gnt) begin m_data_await_gnt = 0; m_data_in_flight = 1; end
    end else if (data_req) begin
      if (data_gnt) m_data_in_flight = 1; else m_data_await_gnt = 1;
    end
    if (m_mdu_left > 0) m_mdu_left--;
    else if (mdu_start && LAT > 1) m_mdu_left = LAT - 1;
  endtask

  task automatic clear_inputs();
    fetch_en = 0; instr_gnt = 0; instr_rvalid = 0;
    data_req = 0; data_gnt = 0; data_rvalid = 0;
    rs1 = 0; rs2 = 0; ex_rd = 0; wb_rd = 0;
    rs1_used = 0; rs2_used = 0; ex_we = 0; wb_we = 0;
    mdu_start = 0; branch = 0;
  endtask

  task automatic step(input string tag);
    logic [8:0] exp_v, obs_v;
    @(negedge clk);
    exp_v = model_expect();
    obs_v = {instr_req, pc_en, data_req_en, s_if_id, s_id_ex, s_ex_wb,
             f_if_id, f_id_ex, f_ex_wb};
    vectors++;
    $display("cyc %0d %s out=%b", cyc, tag, obs_v);
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs_v, exp_v);
    end
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    step("reset");
    step("reset");
    rst_n = 1;
    step("idle");

    // Fetch start: request from the next cycle, pc_en only with rvalid.
    fetch_en = 1;     step("fetch_en");
    fetch_en = 0;     step("req");
    instr_gnt = 1;    step("gnt");
    instr_gnt = 0;    step("wait");
    instr_rvalid = 1; step("rvalid");
    instr_rvalid = 0;

    // Load with delayed grant then response.
    data_req = 1;
    repeat (3) step("ld_nogrant");
    data_gnt = 1;     step("ld_gnt");
    data_gnt = 0;     step("ld_wait");
    data_rvalid = 1;  step("ld_rvalid");
    data_rvalid = 0; data_req = 0;
    step("ld_done");

    // RAW hazards against EX, then WB, then x0.
    rs1 = 5; rs1_used = 1; ex_rd = 5; ex_we = 1; step("raw_ex");
    ex_we = 0; wb_rd = 5; wb_we = 1;              step("raw_wb");
    wb_we = 0; rs1 = 0; ex_rd = 0; ex_we = 1;     step("raw_x0");
    rs2 = 7; rs2_used = 1; ex_rd = 7;             step("raw_rs2");
    clear_inputs();

    // Branch while a fetch is outstanding: next word is dropped.
    instr_gnt = 1;    step("gnt2");
    instr_gnt = 0;
    branch = 1;       step("branch");
    branch = 0;
    instr_rvalid = 1; step("drop");
    instr_rvalid = 0; step("refetch_req");
    instr_gnt = 1;    step("refetch_gnt");
    instr_gnt = 0;
    instr_rvalid = 1; step("refetch_data");
    instr_rvalid = 0;

    // Multi-cycle MDU.
    mdu_start = 1;    step("mdu_start");
    mdu_start = 0;
    repeat (5) step("mdu");

    // Branch held behind a data stall.
    data_req = 1; data_gnt = 1; branch = 1; step("br_ds0");
    data_gnt = 0;                           step("br_ds1");
    data_rvalid = 1;                        step("br_ds_rv");
    data_rvalid = 0; data_req = 0; branch = 0;
    step("br_after");

    // Randomized traffic, occasional mid-transaction reset.
    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      fetch_en     = ($urandom_range(0, 9) == 0);
      instr_gnt    = $urandom_range(0, 1);
      instr_rvalid = $urandom_range(0, 1);
      data_req     = ($urandom_range(0, 3) == 0);
      data_gnt     = $urandom_range(0, 1);
      data_rvalid  = $urandom_range(0, 1);
      rs1          = AW'($urandom_range(0, 3));
      rs2          = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      wb_rd        = AW'($urandom_range(0, 3));
      rs1_used     = $urandom_range(0, 1);
      rs2_used     = $urandom_range(0, 1);
      ex_we        = ($urandom_range(0, 3) == 0);
      wb_we        = ($urandom_range(0, 3) == 0);
      mdu_start    = ($urandom_range(0, 15) == 0);
      branch       = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
